// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN lets trivial operations skip the iteration phase.
`timescale 1ns/1ps
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      dst,
   input  logic            flush,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic            wr_en,
   output logic [4:0]      wr_rd,
   output logic [XLEN-1:0] result
);
   // state  | meaning
   // S_IDLE | waiting for start, ready=1
   // S_CALC | one multiply/divide iteration per cycle
   // S_DONE | one-cycle write-back strobe
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   m_q, hi_q, lo_q, spec_val_q;
   logic              neg_q, neg_r, spec_q;

   logic              a_sgn, b_sgn, neg_a, neg_b, div_zero_in, ovf_in, spec_in;
   logic [XLEN-1:0]   mag_a, mag_b, spec_val_in;
   logic [XLEN:0]     mul_sum, div_trial, div_sub;
   logic              div_ge;
   logic [XLEN-1:0]   hi_n, lo_n, quo_fix, rem_fix, fin_res;
   logic [2*XLEN-1:0] prod_fix;

   always_comb begin
      a_sgn       = (~op[2] & (op[1:0] != 2'b11)) | (op[2] & ~op[0]);
      b_sgn       = (~op[2] & ~op[1]) | (op[2] & ~op[0]);
      neg_a       = a_sgn & src_a[XLEN-1];
      neg_b       = b_sgn & src_b[XLEN-1];
      mag_a       = neg_a ? -src_a : src_a;
      mag_b       = neg_b ? -src_b : src_b;
      div_zero_in = op[2] & (src_b == '0);
      ovf_in      = op[2] & ~op[0] & (src_a == MIN_NEG) & (src_b == '1);
      spec_in     = div_zero_in | ovf_in;
      spec_val_in = '0;
      if (div_zero_in)
         spec_val_in = op[1] ? src_a : '1;
      else if (ovf_in)
         spec_val_in = op[1] ? '0 : MIN_NEG;
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic mul_zero_in;
   assign mul_zero_in = ~op[2] & ((src_a == '0) | (src_b == '0));
`endif

   // hi holds partial product / partial remainder, lo holds multiplier / dividend-quotient
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      div_trial = {hi_q, lo_q[XLEN-1]};
      div_ge    = div_trial >= {1'b0, m_q};
      div_sub   = div_trial - {1'b0, m_q};
      if (op_q[2]) begin
         hi_n = div_ge ? div_sub[XLEN-1:0] : div_trial[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      quo_fix  = neg_q ? -lo_n : lo_n;
      rem_fix  = neg_r ? -hi_n : hi_n;
      case (op_q)
         3'b000:                 fin_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_res = quo_fix;
         default:                fin_res = rem_fix;
      endcase
      if (spec_q)
         fin_res = spec_val_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= '0;
         m_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         spec_val_q <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         spec_q     <= 1'b0;
         ready      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_en      <= 1'b0;
         wr_rd      <= '0;
         result     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done  <= 1'b0;
               wr_en <= 1'b0;
               if (start && !flush) begin
                  op_q       <= op;
                  m_q        <= op[2] ? mag_b : mag_a;
                  lo_q       <= op[2] ? mag_a : mag_b;
                  hi_q       <= '0;
                  neg_q      <= neg_a ^ neg_b;
                  neg_r      <= neg_a;
                  spec_q     <= spec_in;
                  spec_val_q <= spec_val_in;
                  wr_rd      <= dst;
                  cnt        <= '0;
                  ready      <= 1'b0;
                  busy       <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                  if (spec_in || mul_zero_in) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     wr_en  <= (dst != 5'd0);
                     result <= spec_in ? spec_val_in : '0;
                  end else begin
                     state <= S_CALC;
                  end
`else
                  state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  wr_en <= 1'b0;
               end else begin
                  hi_q <= hi_n;
                  lo_q <= lo_n;
                  cnt  <= cnt + 1'b1;
                  if (cnt == {CNT_W{1'b1}}) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     wr_en  <= (wr_rd != 5'd0);
                     result <= fin_res;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
               wr_en <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus per-cycle handshake compare.
`timescale 1ns/1ps
module tb_muldiv_unit;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] src_a = '0, src_b = '0;
   logic [4:0]  dst = '0;
   logic        ready, busy, done, wr_en;
   logic [4:0]  wr_rd;
   logic [31:0] result;

   muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .dst(dst), .flush(flush), .ready(ready), .busy(busy), .done(done), .wr_en(wr_en),
      .wr_rd(wr_rd), .result(result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int          checks = 0, failures = 0;
   bit          mon_en = 1'b0, pend = 1'b0, pend_lit_en = 1'b0, lit_en = 1'b0;
   int          due = 0, rst_chk = -1;
   logic [31:0] pend_res = '0, pend_lit = '0, lit_val = '0;
   logic [4:0]  pend_rd = '0;

   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      p  = '0;
      case (o)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (o[2] && b == 32'd0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (!o[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
      return 33;
   endfunction

   // drive one cycle of inputs and advance the model to match what the unit must do at the next edge
   task automatic cycle(input bit st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit fl, input bit rs);
      @(negedge clk); #1;
      start = st; op = o; src_a = a; src_b = b; dst = d; flush = fl; reset = rs;
      if (rs) begin
         pend = 1'b0;
         rst_chk = cyc + 1;
      end else if (fl) begin
         pend = 1'b0;
      end else if (st && !(pend && cyc <= due)) begin
         pend        = 1'b1;
         due         = cyc + lat_of(o, a, b);
         pend_res    = ref_result(o, a, b);
         pend_rd     = d;
         pend_lit_en = lit_en;
         pend_lit    = lit_val;
      end
      lit_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit le, input logic [31:0] lv);
      lit_en  = le;
      lit_val = lv;
      cycle(1'b1, o, a, b, d, 1'b0, 1'b0);
      idle(lat_of(o, a, b) + 1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      bit b_e, d_e, w_e;
      if (mon_en) begin
         b_e = pend && (cyc <= due);
         d_e = pend && (cyc == due);
         w_e = d_e && (pend_rd != 5'd0);
         checks++;
         if ({ready, busy, done, wr_en} !== {!b_e, b_e, d_e, w_e}) begin
            failures++;
            $display("FAIL ctrl cyc=%0d rdy/bsy/done/wen got=%b exp=%b", cyc, {ready, busy, done, wr_en}, {!b_e, b_e, d_e, w_e});
         end
         if (d_e) begin
            checks++;
            if (result !== pend_res) begin
               failures++;
               $display("FAIL result cyc=%0d got=%h exp=%h", cyc, result, pend_res);
            end
            checks++;
            if (wr_rd !== pend_rd) begin
               failures++;
               $display("FAIL wr_rd cyc=%0d got=%0d exp=%0d", cyc, wr_rd, pend_rd);
            end
            if (pend_lit_en) begin
               checks++;
               if (result !== pend_lit) begin
                  failures++;
                  $display("FAIL literal cyc=%0d got=%h exp=%h", cyc, result, pend_lit);
               end
            end
         end
         if (cyc == rst_chk) begin
            checks++;
            if ({wr_rd, result} !== 37'd0) begin
               failures++;
               $display("FAIL reset_vals cyc=%0d wr_rd=%0d result=%h exp 0/0", cyc, wr_rd, result);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      mon_en = 1'b1;
      idle(2);

      run_op(3'd0, 32'd7,         32'hFFFF_FFFA, 5'd5,  1'b1, 32'hFFFF_FFD6);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b1, 32'hFFFF_FFFE);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b1, 32'h0000_0000);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  1'b1, 32'hFFFF_FFFF);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  1'b1, 32'hFFFF_FFFD);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  1'b1, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd100,       32'd7,         5'd7,  1'b1, 32'd14);
      run_op(3'd7, 32'd100,       32'd7,         5'd8,  1'b1, 32'd2);
      run_op(3'd4, 32'h1234,      32'd0,         5'd9,  1'b1, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h1234,      32'd0,         5'd10, 1'b1, 32'h1234);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h8000_0000);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'd0);
      run_op(3'd0, 32'd3,         32'd4,         5'd0,  1'b1, 32'd12);
      run_op(3'd0, 32'd0,         32'd55,        5'd13, 1'b1, 32'd0);

      // start held high while busy must not queue a second operation
      lit_en = 1'b1; lit_val = 32'd100;
      cycle(1'b1, 3'd5, 32'd1000, 32'd10, 5'd14, 1'b0, 1'b0);
      repeat (25) cycle(1'b1, 3'd0, $urandom, $urandom, 5'd15, 1'b0, 1'b0);
      idle(12);

      // flush in cycle 10 of the calculation
      cycle(1'b1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b0, 1'b0);
      idle(9);
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      idle(3);

      // reset in cycle 20, then a clean operation
      cycle(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd3, 5'd17, 1'b0, 1'b0);
      idle(19);
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      idle(1);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd18, 1'b1, 32'hFFFF_FFFF);

      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1'b0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
